// File: rtl/muldiv_iter.sv
// Iterative RV64M multiply/divide unit for the Execute stage.
// The unit uses radix-2 shift-add multiply and restoring divide on operand magnitudes.
// The sign is corrected after the last iteration. Divide-by-zero and signed overflow
// finish in one cycle. A flush or reset abandons any operation in flight.
module muldiv_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;     // mul: high product half; div: partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;       // mul: multiplier / low product; div: dividend / quotient
  logic [XLEN-1:0]   opb_q, opb_d;     // mul: multiplicand magnitude; div: divisor magnitude
  logic              is_div_q, is_div_d;
  logic              is_rem_q, is_rem_d;
  logic              word_q, word_d;
  logic              mul_hi_q, mul_hi_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode, evaluated in the accept cycle only
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_val, b_val, a_mag, b_mag, dividend_x;
  logic              b_zero, a_most_neg, b_neg_one, spec_div0, spec_ovf;
  logic [XLEN-1:0]   spec_val;

  // Word multiplies are MULW: the low 32 bits do not depend on sign, so magnitudes are zero-extended.
  assign a_signed   = op[2] ? ~op[0] : (~word & ((op == 3'd1) | (op == 3'd2)));
  assign b_signed   = op[2] ? ~op[0] : (~word & (op == 3'd1));
  assign a_val      = word ? {{(XLEN-32){a_signed & rs1_data[31]}}, rs1_data[31:0]} : rs1_data;
  assign b_val      = word ? {{(XLEN-32){b_signed & rs2_data[31]}}, rs2_data[31:0]} : rs2_data;
  assign a_neg      = a_signed & a_val[XLEN-1];
  assign b_neg      = b_signed & b_val[XLEN-1];
  assign a_mag      = a_neg ? (~a_val + XLEN'(1)) : a_val;
  assign b_mag      = b_neg ? (~b_val + XLEN'(1)) : b_val;
  assign dividend_x = word ? {{(XLEN-32){rs1_data[31]}}, rs1_data[31:0]} : rs1_data;

  assign b_zero     = word ? (rs2_data[31:0] == '0) : (rs2_data == '0);
  assign a_most_neg = word ? (rs1_data[31:0] == 32'h8000_0000) : (rs1_data == {1'b1, {(XLEN-1){1'b0}}});
  assign b_neg_one  = word ? (rs2_data[31:0] == '1) : (rs2_data == '1);
  assign spec_div0  = op[2] & b_zero;
  assign spec_ovf   = op[2] & ~op[0] & a_most_neg & b_neg_one;
  assign spec_val   = spec_div0 ? (op[1] ? dividend_x : '1)
                                : (op[1] ? '0 : dividend_x);

  // One radix-2 step of multiply or restoring divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem;
  logic [XLEN-1:0]   acc_it, lo_it;

  assign mul_sum = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
  assign div_sh  = {acc_q, lo_q[XLEN-1]};
  assign div_ok  = div_sh >= {1'b0, opb_q};
  // The remainder after a successful subtract is below the divisor, so the top bit can be dropped.
  assign div_rem = div_sh[XLEN-1:0] - opb_q;
  assign acc_it  = is_div_q ? (div_ok ? div_rem : div_sh[XLEN-1:0]) : mul_sum[XLEN:1];
  assign lo_it   = is_div_q ? {lo_q[XLEN-2:0], div_ok} : {mul_sum[0], lo_q[XLEN-1:1]};

  // Final sign correction and result selection from the last iteration's values
  logic [2*XLEN-1:0] prod, prod_n;
  logic [XLEN-1:0]   div_v, div_vn, final_val;

  // Select the signed/truncated result that gets registered on completion
  always_comb begin
    prod   = {acc_it, lo_it};
    prod_n = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
    div_v  = is_rem_q ? acc_it : (word_q ? {{(XLEN-32){1'b0}}, lo_it[31:0]} : lo_it);
    div_vn = neg_q ? (~div_v + XLEN'(1)) : div_v;
    if (is_div_q) begin
      final_val = word_q ? {{(XLEN-32){div_vn[31]}}, div_vn[31:0]} : div_vn;
    end else if (word_q) begin
      // After 32 steps the low product word sits in the upper half of lo.
      final_val = {{(XLEN-32){lo_it[XLEN-1]}}, lo_it[XLEN-1:XLEN-32]};
    end else begin
      final_val = mul_hi_q ? prod_n[2*XLEN-1:XLEN] : prod_n[XLEN-1:0];
    end
  end

  // Next-state logic: accept, iterate, complete; flush overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    word_d   = word_q;
    mul_hi_d = mul_hi_q;
    neg_d    = neg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          is_div_d = op[2];
          is_rem_d = op[1];
          word_d   = word;
          mul_hi_d = (op != 3'd0) && !word;
          acc_d    = '0;
          if (op[2]) begin
            lo_d  = word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
            opb_d = b_mag;
            neg_d = op[1] ? a_neg : (a_neg ^ b_neg);
          end else begin
            lo_d  = b_mag;
            opb_d = a_mag;
            neg_d = a_neg ^ b_neg;
          end
          if (spec_div0 || spec_ovf) begin
            result_d = spec_val;
            state_d  = S_DONE;
          end else begin
            cnt_d   = word ? 7'd32 : 7'd64;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_it;
        lo_d  = lo_it;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          result_d = final_val;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      word_q   <= 1'b0;
      mul_hi_q <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      is_rem_q <= is_rem_d;
      word_q   <= word_d;
      mul_hi_q <= mul_hi_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter: results, latencies, special cases, abort paths.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst, start, flush, word;
  logic [2:0]  op;
  logic [63:0] rs1_data, rs2_data;
  logic        busy, done;
  logic [63:0] result;

  int total = 0;
  int passed = 0;
  int fails = 0;

  muldiv_iter #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op), .word(word),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .busy(busy), .done(done), .result(result)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check its latency, busy count, result and single-cycle done
  task automatic op_check(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
    int lat;
    int nb;
    op = o; word = w; rs1_data = a; rs2_data = b; start = 1'b1;
    tick();
    start = 1'b0;
    rs1_data = ~a; rs2_data = ~b; op = ~o; word = ~w;
    lat = 1;
    nb  = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) nb++;
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy cycles"}, 64'(nb), 64'(exp_lat - 1));
    check({tag, " result"}, result, exp);
    tick();
    check({tag, " done width"}, 64'(done), 64'd0);
  endtask

  // Hard time limit in case the DUT never settles
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int nb;
    int first;

    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; word = 1'b0;
    rs1_data = '0; rs2_data = '0;
    repeat (3) tick();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b1;

    // Multiplies
    op_check("MUL 7*-3",     3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    op_check("MULHU -1*2",   3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
    op_check("MULH -1*2",    3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    op_check("MULHSU 2*max", 3'd2, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65);
    op_check("MULH -1*-1",   3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    op_check("MULHU max*max",3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    op_check("MULHSU -1*max",3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    op_check("MULW",         3'd1, 1'b1, 64'hDEAD_BEEF_0001_0000, 64'h1234_5678_0000_8000, 64'hFFFF_FFFF_8000_0000, 33);

    // Single-cycle special cases
    op_check("DIVU by 0",    3'd5, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    op_check("REM by 0",     3'd6, 1'b0, 64'd100, 64'd0, 64'd100, 1);
    op_check("DIV ovf",      3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    op_check("REM ovf",      3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    op_check("DIVUW by 0",   3'd5, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    op_check("REMUW by 0",   3'd7, 1'b1, 64'h0000_0001_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);
    op_check("DIVW ovf",     3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    op_check("REMW ovf",     3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1);

    // Iterative divides
    op_check("DIVW -7/2",    3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    op_check("REMW -7/2",    3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    op_check("DIV -100/7",   3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    op_check("REM -100/7",   3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    op_check("DIVU max/10",  3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'h1999_9999_9999_9999, 65);
    op_check("REMU max/10",  3'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, 65);

    // Flush during a MUL at cycle 10
    op = 3'd0; word = 1'b0; rs1_data = 64'd7; rs2_data = 64'hFFFF_FFFF_FFFF_FFFD; start = 1'b1;
    tick();
    start = 1'b0;
    check("flush pre busy", 64'(busy), 64'd1);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush result kept", result, 64'd5);
    op_check("DIVU after flush", 3'd5, 1'b0, 64'd10, 64'd3, 64'd3, 65);

    // Flush and start together in IDLE: nothing accepted
    op = 3'd5; word = 1'b0; rs1_data = 64'd10; rs2_data = 64'd0; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush+start done", 64'(done), 64'd0);
    check("flush+start busy", 64'(busy), 64'd0);
    check("flush+start result", result, 64'd3);

    // Reset during a DIV at cycle 20
    op = 3'd4; word = 1'b0; rs1_data = 64'hFFFF_FFFF_FFFF_FF9C; rs2_data = 64'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset result", result, 64'd0);
    op_check("DIVU after reset", 3'd5, 1'b0, 64'd10, 64'd3, 64'd3, 65);

    // start held high through a MUL: one accept, DONE-cycle start ignored
    op = 3'd0; word = 1'b0; rs1_data = 64'd7; rs2_data = 64'hFFFF_FFFF_FFFF_FFFD; start = 1'b1;
    ndone = 0; nb = 0; first = -1;
    for (int c = 1; c <= 66; c++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c;
      end
      if (busy === 1'b1) nb++;
    end
    check("held done count", 64'(ndone), 64'd1);
    check("held done cycle", 64'(first), 64'd65);
    check("held busy cycles", 64'(nb), 64'd64);
    check("held result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("held idle after done", 64'(busy), 64'd0);
    tick();
    check("held reaccept busy", 64'(busy), 64'd1);
    start = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("held final flush busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV64M multiply/divide unit in the Execute stage.
- Consumes the operand values held in the ID/EX pipeline register and produces one 64-bit result per operation.
- Holds the pipeline via busy while computing. The hazard unit ORs start|busy into stall.
- A jump/branch flush (jb) aborts any operation in progress.

Parameters:
- XLEN, 64, operand/result width; must be 64.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- flush  input  1  abort current op (driven by jb)
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- word  input  1  1 = *W variant (32-bit operands, sign-extended 32-bit result)
- rs1_data  input  XLEN  operand A (dividend/multiplicand)
- rs2_data  input  XLEN  operand B (divisor/multiplier)
- busy  output  1  high while state is BUSY
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  registered result; holds until the next accepted start

Behaviour:
- Reset: when rst=0 at a posedge, state=IDLE and busy=0, done=0, result=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation; no done is produced.
- States: IDLE, BUSY, DONE.
- IDLE: start=1 and flush=0 → operands latched.
  - Normal op: next state BUSY, counter=ITER, where ITER=32 if word else 64.
  - Special case (below): result computed directly, next state DONE.
- BUSY: one radix-2 iteration per cycle; counter decrements. Counter reaching 0 after the last iteration → DONE, result registered.
- DONE: done=1 for exactly this cycle → IDLE. A start in the DONE cycle is ignored. The earliest next accept is the following IDLE cycle.
- Latency: start accepted in cycle N → done=1 in cycle N+ITER+1 (N+65 for 64-bit, N+33 for word). Special cases: done=1 in cycle N+1.
- busy=1 exactly in BUSY cycles. start while busy is ignored.
- flush=1 in any state → IDLE next cycle. done does not assert and result is unchanged. flush and start in the same IDLE cycle → flush wins, nothing accepted.
- Multiply:
  - Shift-add on operand magnitudes. Final sign correction for signed forms: MULH signed×signed, MULHSU signed rs1 × unsigned rs2.
  - MUL returns product[63:0]; MULH/MULHSU/MULHU return product[127:64].
  - word=1: any multiply op is treated as MULW. Result = sext(product of rs1[31:0], rs2[31:0])[31:0], sign-extended from bit 31.
- Divide:
  - Restoring division on magnitudes, quotient sign = sA^sB, remainder sign = sA.
  - word=1: operands are rs1[31:0]/rs2[31:0], signed or unsigned per op; result is 32-bit, sign-extended to 64.
- Special cases (single-cycle, no BUSY):
  - Divisor zero: DIV/DIVU → all ones (sign-extended 32-bit all ones if word); REM/REMU → dividend (sext of dividend[31:0] if word).
  - Signed overflow, DIV/REM with most-negative dividend (0x8000_0000_0000_0000, or 0x8000_0000 if word) and divisor -1: quotient = dividend, remainder = 0.
- Operand changes on rs1_data/rs2_data/op/word after the accept cycle have no effect.

Test Plan:
- MUL, rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD (-3), start in cycle 0 → busy cycles 1..64, done=1 in cycle 65, result=0xFFFF_FFFF_FFFF_FFEB.
- MULHU, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 → result=0x1. MULH with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 100/0 → done in cycle 1, result=0xFFFF_FFFF_FFFF_FFFF. REM 100/0 → 100. DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000. REM with the same operands → 0.
- DIVW, rs1=0x0000_0000_FFFF_FFF9 (-7 in low 32), rs2=2 → done in cycle 33, result=0xFFFF_FFFF_FFFF_FFFD. REMW with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- Abort paths, all followed by a DIVU 10/3 accepted in the next IDLE cycle:
  - Start MUL, flush=1 in cycle 10 → busy=0 from cycle 11, no done pulse, result unchanged. DIVU 10/3 → result=3.
  - Start DIV, rst=0 in cycle 20 → busy=0, done=0, result=0 in cycle 21. DIVU 10/3 completes normally.
- Start held high continuously through a MUL → only one operation accepted. start in the DONE cycle is ignored; the next accept occurs the cycle after DONE.
